i2s_sample_conditioner: RTL
===========================

# i2s_sample_conditioner

Sits directly downstream of the ESP32 I2S receiver and consumes its static 16-bit `left`/`right` words. It resamples them on a fixed sample-rate tick derived from `clk`. Each captured pair goes through a sequential volume multiply with saturation. The conditioned pair is then presented to the audio mixer over a valid/ready handshake, with overrun detection.

## Interface
- `CLK_DIV`, default 583: `clk` cycles per sample tick (≈48 kHz at 28 MHz); must be ≥ 24.
- `clk`  in  1: system clock; all logic on rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `left_in`  in  16: signed left sample from I2S receiver; already in `clk` domain.
- `right_in`  in  16: signed right sample from I2S receiver.
- `vol`  in  8: unsigned gain; 128 = unity, 0 = mute, 255 ≈ ×1.99.
- `out_left`  out  16: conditioned signed left sample.
- `out_right`  out  16: conditioned signed right sample.
- `out_valid`  out  1: pair on `out_left`/`out_right` is valid.
- `out_ready`  in  1: mixer accepts pair when `out_valid && out_ready`.
- `overrun`  out  1: sticky; a tick was dropped.
- `overrun_clr`  in  1: clears `overrun` (single-cycle pulse).

## Operation
- Tick divider: counts `0..CLK_DIV-1` and wraps. `tick` is a 1-cycle pulse when the count equals `CLK_DIV-1`.
- FSM states: IDLE, CAPTURE, MUL_L, MUL_R, DC (only with macro), HOLD.
- IDLE + `tick` → CAPTURE.
  - CAPTURE registers `left_in`, `right_in` and `vol` for one cycle.
  - `vol` changes after CAPTURE do not affect the current pair.
- MUL_L: 8-cycle shift-add, 16×8 → 24-bit signed product.
  - Result = product >>> 7 (arithmetic), saturated to [-32768, 32767].
- MUL_R: identical processing on right → DC (if enabled) → HOLD.
- HOLD: `out_valid`=1.
  - `out_left`/`out_right` stay stable until the handshake.
  - On `out_ready`, the next state is IDLE. If `tick` is high in the same cycle, the next state is CAPTURE (no drop).
- `vol`=0 yields exact 0, not -1 from rounding.
- Overrun: `tick` in any state other than IDLE drops that tick and sets `overrun`. The exception is HOLD with a simultaneous handshake, which is not a drop.
  - Pipeline and held output are unaffected by a drop.
- `overrun_clr` and a new overrun in the same cycle: set wins.

## Timing
- Reset values: `out_left`=0, `out_right`=0, `out_valid`=0, `overrun`=0, FSM=IDLE, divider=0.
  - Multiplier accumulators and DC state are zeroed.
- Reset mid-operation discards the in-flight pair immediately (async). After release, the first tick occurs at divider count `CLK_DIV-1`.
- Latency, `tick` cycle = T:
  - CAPTURE at T+1.
  - MUL_L at T+2..T+9.
  - MUL_R at T+10..T+17.
  - `out_valid` rises at T+18.
  - With DC enabled: +1 cycle (T+19).
- `out_valid` falls the cycle after the handshake unless re-asserted by a new result.
- `out_ready` is ignored while `out_valid`=0.

## Configuration
- `I2S_COND_DC_BLOCK_EN` defined:
  - Adds a per-channel first-order DC blocker after saturation: y[n] = x[n] − x[n−1] + y[n−1] − (y[n−1] >>> 8).
  - Internal width is 18 bits; output is saturated back to 16 bits.
  - Adds the DC state (1 cycle).
  - Filter history updates only on produced pairs, not on dropped ticks.
- Undefined: no DC state; the saturated product goes straight to HOLD; no filter registers are instantiated.

## Structure
- Package `i2s_cond_pkg`:
  - sample width (16), gain width (8), unity shift (7);
  - FSM state enum;
  - saturate-to-16 function.
- Sub-module `serial_mul_16x8`:
  - start/done handshake;
  - 8-cycle signed×unsigned shift-add;
  - instantiated once and time-shared for L then R.
- Divider, FSM, saturation, DC filter and handshake live in the top module.

## Test plan
- Unity gain: `vol`=128, `left_in`=0x1234, `right_in`=0xEDCB, `out_ready`=1.
  - Expected: `out_left`=0x1234, `out_right`=0xEDCB, `out_valid` at T+18, 1 cycle wide.
- Saturation and mute:
  - `vol`=255, `left_in`=0x7000 → `out_left`=0x7FFF.
  - `right_in`=0x9000 → `out_right`=0x8000.
  - `vol`=0 → both outputs 0x0000.
- Backpressure: `out_ready`=0 for 2×`CLK_DIV`.
  - Expected: outputs stay stable, `overrun`=1 after the second tick.
  - `overrun_clr` pulse → `overrun`=0.
  - Handshake coinciding with `tick` → no overrun, next capture proceeds.
- `vol` changed from 128 to 64 at T+5.
  - Expected: current pair is unity; the next pair is halved (0x1000 → 0x0800).
- Async reset: `reset_n` low at T+12.
  - Expected: all outputs 0 immediately, no `out_valid`; after release, the first `out_valid` appears `CLK_DIV`+18 cycles later.
- With `I2S_COND_DC_BLOCK_EN`: constant input 0x4000.
  - Expected: output decays toward 0 (|out| < 0x0100 after 2000 pairs); latency T+19.

Source files
------------

// File: rtl/i2s_cond_pkg.sv
// ============================================================================
// i2s_cond_pkg : shared widths, FSM state encoding and 16-bit saturation
// Rev 1.0
// ============================================================================
`default_nettype none

package i2s_cond_pkg;

  localparam int SAMPLE_W    = 16;
  localparam int GAIN_W      = 8;
  localparam int UNITY_SHIFT = 7;
  localparam int PROD_W      = SAMPLE_W + GAIN_W;
  localparam int DC_W        = 18;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_MUL_L   = 3'd2,
    ST_MUL_R   = 3'd3,
    ST_DC      = 3'd4,
    ST_HOLD    = 3'd5
  } state_t;

  localparam logic signed [PROD_W-1:0] SAT_MAX = 24'sd32767;
  localparam logic signed [PROD_W-1:0] SAT_MIN = -24'sd32768;

  function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [PROD_W-1:0] v);
    logic signed [SAMPLE_W-1:0] r;
    if (v > SAT_MAX)      r = 16'sh7fff;
    else if (v < SAT_MIN) r = 16'sh8000;
    else                  r = v[SAMPLE_W-1:0];
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_mul_16x8.sv
// ============================================================================
// serial_mul_16x8 : 8-cycle shift-add multiplier, signed 16 x unsigned 8
// Rev 1.0
// ============================================================================
`default_nettype none

module serial_mul_16x8
  import i2s_cond_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic signed [SAMPLE_W-1:0] a,
  input  logic        [GAIN_W-1:0]   b,
  output logic                       done,
  output logic signed [PROD_W-1:0]   product
);

  logic signed [PROD_W-1:0] a_sh;
  logic        [GAIN_W-1:0] b_sh;
  logic signed [PROD_W-1:0] acc;
  logic        [2:0]        bit_cnt;
  logic                     busy;
  logic signed [PROD_W-1:0] acc_sum;

  // The final partial product is folded in combinationally so the result is
  // usable in the same cycle that done is raised.
  assign acc_sum = acc + (b_sh[0] ? a_sh : '0);
  assign done    = busy && (bit_cnt == 3'd7);
  assign product = acc_sum;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      acc     <= '0;
      bit_cnt <= '0;
      busy    <= 1'b0;
    end else if (start) begin
      a_sh    <= {{GAIN_W{a[SAMPLE_W-1]}}, a};
      b_sh    <= b;
      acc     <= '0;
      bit_cnt <= '0;
      busy    <= 1'b1;
    end else if (busy) begin
      acc     <= acc_sum;
      a_sh    <= a_sh <<< 1;
      b_sh    <= b_sh >> 1;
      bit_cnt <= bit_cnt + 3'd1;
      if (bit_cnt == 3'd7) busy <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/i2s_sample_conditioner.sv
// ============================================================================
// i2s_sample_conditioner : tick resampler, volume multiply/saturate, optional
// DC blocker (I2S_COND_DC_BLOCK_EN), valid/ready output with overrun flag.
// Rev 1.0
// ============================================================================
`default_nettype none

module i2s_sample_conditioner
  import i2s_cond_pkg::*;
#(
  parameter int CLK_DIV = 583
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic signed [SAMPLE_W-1:0] left_in,
  input  logic signed [SAMPLE_W-1:0] right_in,
  input  logic        [GAIN_W-1:0]   vol,
  output logic signed [SAMPLE_W-1:0] out_left,
  output logic signed [SAMPLE_W-1:0] out_right,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       overrun,
  input  logic                       overrun_clr
);

  localparam int DIV_W = $clog2(CLK_DIV);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  state_t state, state_nxt;

  logic                       mul_start;
  logic signed [SAMPLE_W-1:0] mul_a;
  logic        [GAIN_W-1:0]   mul_b;
  logic                       mul_done;
  logic signed [PROD_W-1:0]   mul_product;
  logic signed [SAMPLE_W-1:0] sat_val;

  logic signed [SAMPLE_W-1:0] cap_left;
  logic signed [SAMPLE_W-1:0] cap_right;
  logic        [GAIN_W-1:0]   cap_vol;
  logic signed [SAMPLE_W-1:0] sat_left;

  logic handshake;
  logic drop;

  assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DIV_W'(1);
  end

  assign out_valid = (state == ST_HOLD);
  assign handshake = out_valid && out_ready;
  assign drop      = tick && (state != ST_IDLE) && !handshake;
  assign sat_val   = sat16(mul_product >>> UNITY_SHIFT);

  serial_mul_16x8 u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (mul_start),
    .a       (mul_a),
    .b       (mul_b),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mul_start = 1'b0;
    mul_a     = cap_left;
    mul_b     = cap_vol;
    case (state)
      ST_IDLE: begin
        if (tick) state_nxt = ST_CAPTURE;
      end
      // Multiplier is fed straight from the ports while the capture
      // registers load, so both see the same sampled values.
      ST_CAPTURE: begin
        mul_start = 1'b1;
        mul_a     = left_in;
        mul_b     = vol;
        state_nxt = ST_MUL_L;
      end
      ST_MUL_L: begin
        if (mul_done) begin
          mul_start = 1'b1;
          mul_a     = cap_right;
          state_nxt = ST_MUL_R;
        end
      end
      ST_MUL_R: begin
`ifdef I2S_COND_DC_BLOCK_EN
        if (mul_done) state_nxt = ST_DC;
`else
        if (mul_done) state_nxt = ST_HOLD;
`endif
      end
`ifdef I2S_COND_DC_BLOCK_EN
      ST_DC: begin
        state_nxt = ST_HOLD;
      end
`endif
      ST_HOLD: begin
        if (out_ready) state_nxt = tick ? ST_CAPTURE : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         overrun <= 1'b0;
    else if (drop)        overrun <= 1'b1;
    else if (overrun_clr) overrun <= 1'b0;
  end

`ifdef I2S_COND_DC_BLOCK_EN
  localparam logic signed [DC_W+1:0] DC_MAX = 20'sd131071;
  localparam logic signed [DC_W+1:0] DC_MIN = -20'sd131072;

  // y[n] = x[n] - x[n-1] + y[n-1] - (y[n-1] >>> 8), clamped to 18 bits
  function automatic logic signed [DC_W-1:0] dc_step(
    input logic signed [SAMPLE_W-1:0] x,
    input logic signed [SAMPLE_W-1:0] xp,
    input logic signed [DC_W-1:0]     yp
  );
    logic signed [DC_W+1:0] xw, xpw, ypw, acc;
    logic signed [DC_W-1:0] r;
    xw  = {{(DC_W+2-SAMPLE_W){x[SAMPLE_W-1]}}, x};
    xpw = {{(DC_W+2-SAMPLE_W){xp[SAMPLE_W-1]}}, xp};
    ypw = {{2{yp[DC_W-1]}}, yp};
    acc = xw - xpw + ypw - (ypw >>> 8);
    if (acc > DC_MAX)      r = DC_MAX[DC_W-1:0];
    else if (acc < DC_MIN) r = DC_MIN[DC_W-1:0];
    else                   r = acc[DC_W-1:0];
    return r;
  endfunction

  logic signed [SAMPLE_W-1:0] sat_right;
  logic signed [SAMPLE_W-1:0] x_prev_l, x_prev_r;
  logic signed [DC_W-1:0]     y_prev_l, y_prev_r;
  logic signed [DC_W-1:0]     dc_y_l, dc_y_r;
  logic signed [PROD_W-1:0]   dc_ext_l, dc_ext_r;

  assign dc_y_l   = dc_step(sat_left, x_prev_l, y_prev_l);
  assign dc_y_r   = dc_step(sat_right, x_prev_r, y_prev_r);
  assign dc_ext_l = {{(PROD_W-DC_W){dc_y_l[DC_W-1]}}, dc_y_l};
  assign dc_ext_r = {{(PROD_W-DC_W){dc_y_r[DC_W-1]}}, dc_y_r};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_left  <= '0;
      cap_right <= '0;
      cap_vol   <= '0;
      sat_left  <= '0;
      out_left  <= '0;
      out_right <= '0;
`ifdef I2S_COND_DC_BLOCK_EN
      sat_right <= '0;
      x_prev_l  <= '0;
      x_prev_r  <= '0;
      y_prev_l  <= '0;
      y_prev_r  <= '0;
`endif
    end else begin
      if (state == ST_CAPTURE) begin
        cap_left  <= left_in;
        cap_right <= right_in;
        cap_vol   <= vol;
      end
      if (state == ST_MUL_L && mul_done) sat_left <= sat_val;
      if (state == ST_MUL_R && mul_done) begin
`ifdef I2S_COND_DC_BLOCK_EN
        sat_right <= sat_val;
`else
        out_left  <= sat_left;
        out_right <= sat_val;
`endif
      end
`ifdef I2S_COND_DC_BLOCK_EN
      if (state == ST_DC) begin
        out_left  <= sat16(dc_ext_l);
        out_right <= sat16(dc_ext_r);
        x_prev_l  <= sat_left;
        x_prev_r  <= sat_right;
        y_prev_l  <= dc_y_l;
        y_prev_r  <= dc_y_r;
      end
`endif
    end
  end

endmodule

`default_nettype wire
